mem_bist32: RTL and testbench

Built-in self-test controller for the 32-bit word memory (`Memoria32`); sits directly upstream of it and drives its write and read ports. On a `start` pulse it fills a window of the memory with an arithmetic pattern, then reads the window back. It compares each returned word against the expected value and reports pass/fail, an error count and the first failing address. It replaces ad-hoc fill/readback sequencing and is reusable for power-on memory checks in the datapath.

---
 rtl/mem_bist_pkg.sv | 22 ++
 rtl/bist_expect_pipe.sv | 37 +++
 rtl/mem_bist32.sv | 146 ++++++++++++++
 tb/tb_mem_bist32.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and widths for the 32-bit memory BIST controller.
package mem_bist_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      GAP,
      READ,
      DRAIN,
      DONE
   } bist_state_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_entry_t;

endpackage

// File: rtl/bist_expect_pipe.sv
// Delay line that pairs each issued read with its address and expected data,
// so both emerge in the cycle the memory returns the word.
module bist_expect_pipe
   import mem_bist_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data
);

   exp_entry_t stage [DEPTH];

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= {push, push_addr, push_data};
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_valid = stage[DEPTH-1].valid;
   assign out_addr  = stage[DEPTH-1].addr;
   assign out_data  = stage[DEPTH-1].data;

endmodule

// File: rtl/mem_bist32.sv
// Memory BIST controller: fills a window with an arithmetic pattern, reads it
// back, and reports pass/fail, a saturating error count and the first bad address.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// WRITE | one pattern word written per cycle
// GAP   | single idle cycle so the last write lands before reading
// READ  | one read issued per cycle, expectation pushed into the pipe
// DRAIN | READ_LATENCY cycles letting the last reads be compared
// DONE  | one-cycle done pulse, pass published
module mem_bist32
   import mem_bist_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0,
   parameter int                NUM_WORDS    = 16,
   parameter logic [ADDR_W-1:0] STRIDE       = 32'd4,
   parameter logic [DATA_W-1:0] PATTERN_INIT = 32'h0,
   parameter logic [DATA_W-1:0] PATTERN_STEP = 32'd4,
   parameter int                READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   output logic [ADDR_W-1:0] waddress,
   output logic [ADDR_W-1:0] raddress,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              Wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam int               CNT_W      = 17;
   localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);
   localparam logic [1:0]       DRAIN_LOAD = 2'(READ_LATENCY - 1);

   bist_state_t       state;
   logic [CNT_W-1:0]  idx_cnt;
   logic [1:0]        drain_cnt;
   logic [DATA_W-1:0] exp_data;
   logic              push;
   logic              cmp_valid;
   logic [ADDR_W-1:0] cmp_addr;
   logic [DATA_W-1:0] cmp_data;
   logic              mismatch;

   assign push     = (state == READ);
   assign mismatch = cmp_valid && (mem_rdata != cmp_data);

   bist_expect_pipe #(
      .DEPTH(READ_LATENCY)
   ) u_expect_pipe (
      .clk      (clk),
      .nrst     (nrst),
      .push     (push),
      .push_addr(raddress),
      .push_data(exp_data),
      .out_valid(cmp_valid),
      .out_addr (cmp_addr),
      .out_data (cmp_data)
   );

   // idx_cnt counts remaining words down to a terminal 0; the running address
   // and pattern registers advance by STRIDE / PATTERN_STEP alongside it.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state          <= IDLE;
         idx_cnt        <= '0;
         drain_cnt      <= '0;
         exp_data       <= '0;
         waddress       <= '0;
         raddress       <= '0;
         mem_wdata      <= '0;
         Wr             <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         done <= 1'b0;
         if (mismatch) begin
            if (err_count == 8'd0) first_err_addr <= cmp_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  err_count      <= '0;
                  first_err_addr <= '0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  idx_cnt        <= LAST_IDX;
                  waddress       <= BASE_ADDR;
                  mem_wdata      <= PATTERN_INIT;
                  Wr             <= 1'b1;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               if (idx_cnt == '0) begin
                  Wr    <= 1'b0;
                  state <= GAP;
               end else begin
                  idx_cnt   <= idx_cnt - 1'b1;
                  waddress  <= waddress + STRIDE;
                  mem_wdata <= mem_wdata + PATTERN_STEP;
               end
            end
            GAP: begin
               idx_cnt  <= LAST_IDX;
               raddress <= BASE_ADDR;
               exp_data <= PATTERN_INIT;
               state    <= READ;
            end
            READ: begin
               if (idx_cnt == '0) begin
                  drain_cnt <= DRAIN_LOAD;
                  state     <= DRAIN;
               end else begin
                  idx_cnt  <= idx_cnt - 1'b1;
                  raddress <= raddress + STRIDE;
                  exp_data <= exp_data + PATTERN_STEP;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  // the final comparison lands on this same edge
                  pass  <= (err_count == 8'd0) && !mismatch;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist32.sv
// Bench for mem_bist32: memory models with fault injection and a reference
// that derives expected results from the addressing/pattern rules directly.
module tb_mem_bist32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic nrst;
   int   checks = 0;
   int   errors = 0;

   // instance A: defaults
   logic        a_start, a_wr, a_busy, a_done, a_pass;
   logic [31:0] a_wa, a_ra, a_wd, a_rd, a_fe;
   logic [7:0]  a_ec;
   // instance B: 300 words, memory always returns all ones
   logic        b_start, b_wr, b_busy, b_done, b_pass;
   logic [31:0] b_wa, b_ra, b_wd, b_rd, b_fe;
   logic [7:0]  b_ec;
   // instance C: window wrapping past 2^32
   logic        c_start, c_wr, c_busy, c_done, c_pass;
   logic [31:0] c_wa, c_ra, c_wd, c_rd, c_fe;
   logic [7:0]  c_ec;
   // instance D: read latency 2
   logic        d_start, d_wr, d_busy, d_done, d_pass;
   logic [31:0] d_wa, d_ra, d_wd, d_rd, d_rd1, d_fe;
   logic [7:0]  d_ec;

   mem_bist32 u_a (
      .clk(clk), .nrst(nrst), .start(a_start), .waddress(a_wa), .raddress(a_ra),
      .mem_wdata(a_wd), .Wr(a_wr), .mem_rdata(a_rd), .busy(a_busy), .done(a_done),
      .pass(a_pass), .err_count(a_ec), .first_err_addr(a_fe));

   mem_bist32 #(.NUM_WORDS(300)) u_b (
      .clk(clk), .nrst(nrst), .start(b_start), .waddress(b_wa), .raddress(b_ra),
      .mem_wdata(b_wd), .Wr(b_wr), .mem_rdata(b_rd), .busy(b_busy), .done(b_done),
      .pass(b_pass), .err_count(b_ec), .first_err_addr(b_fe));

   mem_bist32 #(.BASE_ADDR(32'hFFFF_FFF8), .NUM_WORDS(4)) u_c (
      .clk(clk), .nrst(nrst), .start(c_start), .waddress(c_wa), .raddress(c_ra),
      .mem_wdata(c_wd), .Wr(c_wr), .mem_rdata(c_rd), .busy(c_busy), .done(c_done),
      .pass(c_pass), .err_count(c_ec), .first_err_addr(c_fe));

   mem_bist32 #(.READ_LATENCY(2)) u_d (
      .clk(clk), .nrst(nrst), .start(d_start), .waddress(d_wa), .raddress(d_ra),
      .mem_wdata(d_wd), .Wr(d_wr), .mem_rdata(d_rd), .busy(d_busy), .done(d_done),
      .pass(d_pass), .err_count(d_ec), .first_err_addr(d_fe));

   logic [31:0] mem_a  [logic [31:0]];
   logic [31:0] flip_a [logic [31:0]];
   logic [31:0] mem_c  [logic [31:0]];
   logic [31:0] mem_d  [logic [31:0]];
   logic [63:0] wq_a [$];
   logic [63:0] wq_c [$];

   assign b_rd = 32'hFFFF_FFFF;

   always @(posedge clk) begin
      if (a_wr) mem_a[a_wa] = a_wd;
      a_rd <= (mem_a.exists(a_ra) ? mem_a[a_ra] : 32'h0) ^
              (flip_a.exists(a_ra) ? flip_a[a_ra] : 32'h0);
      if (c_wr) mem_c[c_wa] = c_wd;
      c_rd <= mem_c.exists(c_ra) ? mem_c[c_ra] : 32'h0;
      if (d_wr) mem_d[d_wa] = d_wd;
      d_rd1 <= mem_d.exists(d_ra) ? mem_d[d_ra] : 32'h0;
      d_rd  <= d_rd1;
   end

   always @(negedge clk) begin
      if (a_wr) wq_a.push_back({a_wa, a_wd});
      if (c_wr) wq_c.push_back({c_wa, c_wd});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected outcome of one run: walk the window, compare what the memory
   // would return with the pattern word, count and locate mismatches.
   function automatic void ref_run(input logic [31:0] base, input int n,
                                   input logic [31:0] stride, input logic [31:0] init,
                                   input logic [31:0] step, input bit use_flips,
                                   input bit all_ones, output int ec, output logic [31:0] fe);
      logic [31:0] addr, expd, got;
      ec = 0;
      fe = 32'h0;
      for (int i = 0; i < n; i++) begin
         addr = base + 32'(i) * stride;
         expd = init + 32'(i) * step;
         got  = expd;
         if (use_flips && flip_a.exists(addr)) got = expd ^ flip_a[addr];
         if (all_ones) got = 32'hFFFF_FFFF;
         if (got != expd) begin
            if (ec == 0) fe = addr;
            if (ec < 255) ec++;
         end
      end
   endfunction

   task automatic chk_zero_a(input string tag);
      chk({tag, ".waddress"},  a_wa, 32'h0);
      chk({tag, ".raddress"},  a_ra, 32'h0);
      chk({tag, ".mem_wdata"}, a_wd, 32'h0);
      chk({tag, ".Wr"},        32'(a_wr), 32'h0);
      chk({tag, ".busy"},      32'(a_busy), 32'h0);
      chk({tag, ".done"},      32'(a_done), 32'h0);
      chk({tag, ".pass"},      32'(a_pass), 32'h0);
      chk({tag, ".err_count"}, 32'(a_ec), 32'h0);
      chk({tag, ".first_err"}, a_fe, 32'h0);
   endtask

   task automatic run_a(input string tag, output int lat);
      wq_a.delete();
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      lat = 0;
      while (a_done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk({tag, ".busy_first"}, 32'(a_busy), 32'h1);
      end
   endtask

   task automatic finish_a(input string tag, input int lat, input int ec_exp,
                           input logic [31:0] fe_exp);
      chk({tag, ".latency"},   lat, 32'd35);
      chk({tag, ".done"},      32'(a_done), 32'h1);
      chk({tag, ".busy_done"}, 32'(a_busy), 32'h0);
      chk({tag, ".pass"},      32'(a_pass), 32'(ec_exp == 0));
      chk({tag, ".err_count"}, 32'(a_ec), ec_exp);
      chk({tag, ".first_err"}, a_fe, fe_exp);
      chk({tag, ".n_writes"},  wq_a.size(), 32'd16);
      for (int i = 0; i < wq_a.size() && i < 16; i++) begin
         chk({tag, ".waddr"}, wq_a[i][63:32], 32'(i) * 32'd4);
         chk({tag, ".wdata"}, wq_a[i][31:0],  32'(i) * 32'd4);
      end
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(a_done), 32'h0);
      chk({tag, ".pass_hold"},  32'(a_pass), 32'(ec_exp == 0));
   endtask

   initial begin
      int          lat;
      int          ec_exp;
      logic [31:0] fe_exp;
      int          nf;
      nrst    = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      c_start = 1'b0;
      d_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero_a("reset");
      chk("reset.b_err_count", 32'(b_ec), 32'h0);
      chk("reset.d_busy", 32'(d_busy), 32'h0);
      #1 nrst = 1'b0;
      repeat (2) @(posedge clk);

      flip_a.delete();
      ref_run(32'h0, 16, 32'd4, 32'h0, 32'd4, 1'b1, 1'b0, ec_exp, fe_exp);
      run_a("dflt", lat);
      finish_a("dflt", lat, ec_exp, fe_exp);

      flip_a[32'd24] = 32'h1;
      ref_run(32'h0, 16, 32'd4, 32'h0, 32'd4, 1'b1, 1'b0, ec_exp, fe_exp);
      run_a("bad24", lat);
      finish_a("bad24", lat, ec_exp, fe_exp);
      chk("bad24.addr_literal", a_fe, 32'd24);

      for (int r = 0; r < 5; r++) begin
         flip_a.delete();
         nf = int'($urandom_range(0, 3));
         for (int j = 0; j < nf; j++) begin
            flip_a[32'($urandom_range(0, 15)) * 32'd4] = 32'h1 << $urandom_range(0, 31);
         end
         ref_run(32'h0, 16, 32'd4, 32'h0, 32'd4, 1'b1, 1'b0, ec_exp, fe_exp);
         run_a("rand", lat);
         finish_a("rand", lat, ec_exp, fe_exp);
      end

      // reset while reading, with one error already accumulated
      flip_a.delete();
      flip_a[32'd0] = 32'h8000_0000;
      @(posedge clk); #1 a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      repeat (22) @(negedge clk);
      chk("rst.pre_err_count", 32'(a_ec), 32'h1);
      chk("rst.pre_busy", 32'(a_busy), 32'h1);
      #2 nrst = 1'b1;
      #1 chk_zero_a("rst.async");
      @(posedge clk); #1 nrst = 1'b0;
      repeat (2) @(posedge clk);
      flip_a.delete();
      ref_run(32'h0, 16, 32'd4, 32'h0, 32'd4, 1'b1, 1'b0, ec_exp, fe_exp);
      run_a("rerun", lat);
      finish_a("rerun", lat, ec_exp, fe_exp);

      // saturation
      ref_run(32'h0, 300, 32'd4, 32'h0, 32'd4, 1'b0, 1'b1, ec_exp, fe_exp);
      @(posedge clk); #1 b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      lat = 0;
      while (b_done !== 1'b1 && lat < 700) begin
         @(negedge clk);
         lat++;
      end
      chk("sat.latency",   lat, 32'd603);
      chk("sat.err_count", 32'(b_ec), ec_exp);
      chk("sat.err_255",   32'(b_ec), 32'd255);
      chk("sat.first_err", b_fe, fe_exp);
      chk("sat.pass",      32'(b_pass), 32'h0);

      // address wrap
      ref_run(32'hFFFF_FFF8, 4, 32'd4, 32'h0, 32'd4, 1'b0, 1'b0, ec_exp, fe_exp);
      wq_c.delete();
      @(posedge clk); #1 c_start = 1'b1;
      @(posedge clk); #1 c_start = 1'b0;
      lat = 0;
      while (c_done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("wrap.latency",   lat, 32'd11);
      chk("wrap.pass",      32'(c_pass), 32'(ec_exp == 0));
      chk("wrap.err_count", 32'(c_ec), ec_exp);
      chk("wrap.n_writes",  wq_c.size(), 32'd4);
      for (int i = 0; i < wq_c.size() && i < 4; i++) begin
         chk("wrap.waddr", wq_c[i][63:32], 32'hFFFF_FFF8 + 32'(i) * 32'd4);
         chk("wrap.wdata", wq_c[i][31:0], 32'(i) * 32'd4);
      end

      // latency 2, start while busy and in DONE both ignored
      ref_run(32'h0, 16, 32'd4, 32'h0, 32'd4, 1'b0, 1'b0, ec_exp, fe_exp);
      @(posedge clk); #1 d_start = 1'b1;
      @(posedge clk); #1 d_start = 1'b0;
      lat = 0;
      while (d_done !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 5) d_start = 1'b1;
         if (lat == 6) d_start = 1'b0;
      end
      chk("rl2.latency",   lat, 32'd36);
      chk("rl2.pass",      32'(d_pass), 32'(ec_exp == 0));
      chk("rl2.err_count", 32'(d_ec), ec_exp);
      d_start = 1'b1;
      @(posedge clk); #1 d_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rl2.start_in_done_busy", 32'(d_busy), 32'h0);
      chk("rl2.start_in_done_wr",   32'(d_wr), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
